muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit for the 32IM core. It sits in the execute stage beside the ALU. Decode supplies `OPCODE_OP` instructions with funct7 = 0000001 together with the `md_funct3_e` operation code. The unit takes operands from register read, holds a busy/stall indication for the pipeline, and returns one registered result per operation to memory/WB.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `clk` input 1: core clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start_i` input 1: request a new operation. Sampled only in IDLE.
- `funct3_i` input 3: operation, encoded as `md_funct3_e`.
  - MUL=000, MULH=001, MULHSU=010, MULHU=011
  - DIV=100, DIVU=101, REM=110, REMU=111
- `op_a_i` input XLEN: rs1 value (multiplicand/dividend).
- `op_b_i` input XLEN: rs2 value (multiplier/divisor).
- `flush_i` input 1: synchronous abort from pipeline flush/trap.
- `busy_o` output 1: high whenever state != IDLE. Drives the pipeline stall.
- `done_o` output 1: one-cycle pulse; `result_o` is valid in that cycle.
- `result_o` output XLEN: registered result. Holds its value until the next completion.

## Operation
- **States:** IDLE, ITER, DONE.
- **IDLE:**
  - On `start_i` with `flush_i` low, latch funct3 and operands.
  - Take absolute values of signed operands:
    - MULH, DIV, REM: both operands signed.
    - MULHSU: `op_a_i` signed, `op_b_i` unsigned.
    - MUL: treated as unsigned; the low 32 bits are sign-agnostic.
  - Record the result sign:
    - Products and quotients: sign(a) XOR sign(b).
    - Remainders: sign(a).
  - Load the 6-bit iteration counter with 31 and go to ITER.
- **Special cases:** these go straight to DONE without entering ITER.
  - Divide by zero (`op_b_i` = 0):
    - DIV/DIVU return 0xFFFFFFFF.
    - REM/REMU return `op_a_i`.
  - Signed overflow (DIV/REM with `op_a_i` = 0x80000000 and `op_b_i` = 0xFFFFFFFF):
    - DIV returns 0x80000000.
    - REM returns 0.
- **ITER, multiply:** shift-add on a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- **ITER, divide:** radix-2 restoring division, one quotient bit per cycle, MSB first. Uses a 33-bit trial subtract of the partial remainder and divisor magnitude.
- **Leaving ITER:** when the counter reaches 0, go to DONE. On that edge, load `result_o` with the sign-corrected value:
  - MUL: low 32 bits of the product.
  - MULH/MULHSU/MULHU: high 32 bits of the product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Negation is two's complement, applied across the full 64-bit product before the word is selected.
- **DONE:** `done_o`=1 for exactly one cycle, then go to IDLE unconditionally. `start_i` is ignored in DONE.
- **Flush:**
  - `flush_i` in any state returns the unit to IDLE on the next edge.
  - No `done_o` is produced and `result_o` is unchanged.
  - `flush_i` together with `start_i` in IDLE means the request is dropped.
  - If `flush_i` arrives in DONE, it suppresses nothing: `done_o` is already high that cycle.
- **Reset:** state IDLE, counter 0; `busy_o`=0, `done_o`=0, `result_o`=0. Reset during ITER discards the operation immediately.

## Timing
- Start sampled at edge T.
- **Normal operation:**
  - ITER occupies cycles T+1..T+32.
  - DONE (`done_o`=1, `result_o` valid) in cycle T+33.
  - Earliest next start is sampled at the edge ending T+34 (in IDLE).
  - `busy_o` is high T+1..T+33.
- **Special cases:** DONE in cycle T+1; `busy_o` high for T+1 only.
- `result_o` changes only on the edge entering DONE.
- No combinational path from inputs to outputs.

## Configuration
- **`MULDIV_FAST_MUL_EN`**
  - **Defined:**
    - All multiply ops use a single-cycle 33x33 signed multiplier.
    - Operands are extended as signed or unsigned per funct3, and the product is registered on the edge entering DONE.
    - Multiply latency is DONE in T+1.
    - Division is unchanged.
  - **Undefined:** the iterative shift-add path with 32-cycle latency; no hardware multiplier is inferred.

## Test plan
- **DIV basic:** DIV a=-7 (0xFFFFFFF9), b=2 → `done_o` at T+33, result 0xFFFFFFFD (-3). REM of the same operands → 0xFFFFFFFF (-1).
- **Divide by zero:** DIVU a=0x12345678, b=0 → `done_o` at T+1, result 0xFFFFFFFF. REMU of the same operands → 0x12345678.
- **Signed overflow:** DIV a=0x80000000, b=0xFFFFFFFF → result 0x80000000 at T+1. REM of the same operands → 0.
- **Multiply high words:**
  - MULH a=0x80000000, b=0x80000000 → 0x40000000.
  - MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
  - MULHU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFE.
  - MUL of the same operands → 0x00000001.
  - Latency is T+33, or T+1 with `MULDIV_FAST_MUL_EN`.
- **Flush mid-operation:** `flush_i` at T+10 of a DIV → no `done_o`, `busy_o` low from T+11, `result_o` keeps its prior value. A new start at T+11 completes at T+44.
- **Reset and back-to-back:**
  - `rst_n` low during ITER → all outputs 0 immediately.
  - `start_i` held high continuously → one completion every 34 cycles. Starts during ITER/DONE are ignored.

Source files
------------

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the execute stage and muldiv_unit.
// The master drives the operation request and flush; the slave (the unit) returns busy/done/result.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] op_a_i;
    logic [XLEN-1:0] op_b_i;
    logic            flush_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, funct3_i, op_a_i, op_b_i, flush_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, funct3_i, op_a_i, op_b_i, flush_i,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide (shift-add multiply, restoring divide, 32 cycles each).
// Define MULDIV_FAST_MUL_EN to replace the multiply path with a single-cycle 33x33 signed multiplier.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic    clk,
    input  logic    rst_n,
    muldiv_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;
    typedef enum logic [2:0] {
        MD_MUL = 3'b000, MD_MULH = 3'b001, MD_MULHSU = 3'b010, MD_MULHU = 3'b011,
        MD_DIV = 3'b100, MD_DIVU = 3'b101, MD_REM  = 3'b110, MD_REMU  = 3'b111
    } md_funct3_e;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    md_funct3_e        op_q, op_d;
    logic [5:0]        cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   divisor_q, divisor_d;
    logic [XLEN-1:0]   result_q, result_d;

    md_funct3_e      funct3In;
    logic            isDivIn, signedAIn, signedBIn, signAIn, signBIn, negIn;
    logic            divByZero, overflow;
    logic [XLEN-1:0] absA, absB, specialRes;

    always_comb begin
        funct3In  = md_funct3_e'(bus.funct3_i);
        isDivIn   = bus.funct3_i[2];
        signedAIn = funct3In inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
        signedBIn = funct3In inside {MD_MULH, MD_DIV, MD_REM};
        signAIn   = signedAIn && bus.op_a_i[XLEN-1];
        signBIn   = signedBIn && bus.op_b_i[XLEN-1];
        absA      = signAIn ? -bus.op_a_i : bus.op_a_i;
        absB      = signBIn ? -bus.op_b_i : bus.op_b_i;
        negIn     = (funct3In inside {MD_REM, MD_REMU}) ? signAIn : (signAIn ^ signBIn);
        divByZero = isDivIn && (bus.op_b_i == '0);
        overflow  = (funct3In inside {MD_DIV, MD_REM}) && (bus.op_a_i == MIN_INT) && (bus.op_b_i == '1);
        if (divByZero) begin
            specialRes = bus.funct3_i[1] ? bus.op_a_i : '1;
        end else begin
            specialRes = bus.funct3_i[1] ? '0 : MIN_INT;
        end
    end

    // acc holds {product high, multiplier} when multiplying and {remainder, dividend/quotient} when dividing
    logic [XLEN:0]     mulSum, remShift, trialDiff;
    logic              quoBit;
    logic [2*XLEN-1:0] mulNext, divNext, stepAcc, signedProd;
    logic [XLEN-1:0]   divWord, finalRes;

    always_comb begin
        mulSum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, divisor_q} : '0);
        mulNext    = {mulSum, acc_q[XLEN-1:1]};
        remShift   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        trialDiff  = remShift - {1'b0, divisor_q};
        quoBit     = ~trialDiff[XLEN];
        divNext    = {quoBit ? trialDiff[XLEN-1:0] : remShift[XLEN-1:0], acc_q[XLEN-2:0], quoBit};
        stepAcc    = op_q[2] ? divNext : mulNext;
        signedProd = neg_q ? -stepAcc : stepAcc;
        divWord    = op_q[1] ? stepAcc[2*XLEN-1:XLEN] : stepAcc[XLEN-1:0];
        if (op_q[2]) begin
            finalRes = neg_q ? -divWord : divWord;
        end else if (op_q == MD_MUL) begin
            finalRes = signedProd[XLEN-1:0];
        end else begin
            finalRes = signedProd[2*XLEN-1:XLEN];
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fastA, fastB;
    logic signed [2*XLEN+1:0] fastProd;
    logic [XLEN-1:0]          fastRes;

    always_comb begin
        fastA    = {signedAIn & bus.op_a_i[XLEN-1], bus.op_a_i};
        fastB    = {signedBIn & bus.op_b_i[XLEN-1], bus.op_b_i};
        fastProd = fastA * fastB;
        fastRes  = (funct3In == MD_MUL) ? fastProd[XLEN-1:0] : fastProd[2*XLEN-1:XLEN];
    end
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        acc_d     = acc_q;
        divisor_d = divisor_q;
        result_d  = result_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i && !bus.flush_i) begin
                    op_d      = funct3In;
                    neg_d     = negIn;
                    acc_d     = {{XLEN{1'b0}}, isDivIn ? absA : absB};
                    divisor_d = isDivIn ? absB : absA;
                    cnt_d     = 6'd31;
                    if (divByZero || overflow) begin
                        state_d  = DONE;
                        result_d = specialRes;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!isDivIn) begin
                        state_d  = DONE;
                        result_d = fastRes;
                    end
`endif
                    else begin
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                if (bus.flush_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d = stepAcc;
                    if (cnt_q == 6'd0) begin
                        state_d  = DONE;
                        result_d = finalRes;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= MD_MUL;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            divisor_q <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            acc_q     <= acc_d;
            divisor_q <= divisor_d;
            result_q  <= result_d;
        end
    end

    assign bus.busy_o   = (state_q != IDLE);
    assign bus.done_o   = (state_q == DONE);
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (latency, results, flush, reset, back-to-back).
// Expected multiply latency follows MULDIV_FAST_MUL_EN when it is defined for the build.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int fails = 0;

    muldiv_if #(.XLEN(32)) bus ();
    muldiv_unit #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Issues one operation from IDLE and reports the cycle offset of done_o (-1 on timeout) and the result.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 output int lat, output logic [31:0] res);
        @(negedge clk);
        for (int w = 0; w < 100 && bus.busy_o; w++) @(negedge clk);
        bus.funct3_i = f3;
        bus.op_a_i   = a;
        bus.op_b_i   = b;
        bus.start_i  = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        lat = -1;
        res = 'x;
        for (int k = 1; k <= 60; k++) begin
            if (bus.done_o) begin
                lat = k;
                res = bus.result_o;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (bus.busy_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy_o); end
        checks++; if (bus.done_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done_o); end
        checks++; if (bus.result_o !== 32'h0) begin fails++; $display("[TB] FAIL reset_result: got %h expected 00000000", bus.result_o); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_div();
        int lat; logic [31:0] res;
        applyStimulus(F_DIV, 32'hFFFFFFF9, 32'h2, lat, res);
        checks++; if (lat !== 33) begin fails++; $display("[TB] FAIL div_latency: got %0d expected 33", lat); end
        checks++; if (res !== 32'hFFFFFFFD) begin fails++; $display("[TB] FAIL div_neg7_2: got %h expected FFFFFFFD", res); end
        applyStimulus(F_REM, 32'hFFFFFFF9, 32'h2, lat, res);
        checks++; if (res !== 32'hFFFFFFFF || lat !== 33) begin fails++; $display("[TB] FAIL rem_neg7_2: got %h lat %0d expected FFFFFFFF lat 33", res, lat); end
        applyStimulus(F_DIV, 32'd20, 32'hFFFFFFFD, lat, res);
        checks++; if (res !== 32'hFFFFFFFA) begin fails++; $display("[TB] FAIL div_20_neg3: got %h expected FFFFFFFA", res); end
        applyStimulus(F_REM, 32'd20, 32'hFFFFFFFD, lat, res);
        checks++; if (res !== 32'h2) begin fails++; $display("[TB] FAIL rem_20_neg3: got %h expected 00000002", res); end
        applyStimulus(F_DIVU, 32'hFFFFFFFF, 32'h10, lat, res);
        checks++; if (res !== 32'h0FFFFFFF) begin fails++; $display("[TB] FAIL divu_big: got %h expected 0FFFFFFF", res); end
        applyStimulus(F_REMU, 32'hFFFFFFFF, 32'h10, lat, res);
        checks++; if (res !== 32'hF) begin fails++; $display("[TB] FAIL remu_big: got %h expected 0000000F", res); end
    endtask

    task automatic test_div_zero();
        int lat; logic [31:0] res;
        applyStimulus(F_DIVU, 32'h12345678, 32'h0, lat, res);
        checks++; if (lat !== 1) begin fails++; $display("[TB] FAIL divzero_latency: got %0d expected 1", lat); end
        checks++; if (res !== 32'hFFFFFFFF) begin fails++; $display("[TB] FAIL divu_zero: got %h expected FFFFFFFF", res); end
        @(posedge clk); #1;
        checks++; if (bus.busy_o !== 1'b0) begin fails++; $display("[TB] FAIL divzero_busy_T2: got %b expected 0", bus.busy_o); end
        applyStimulus(F_REMU, 32'h12345678, 32'h0, lat, res);
        checks++; if (res !== 32'h12345678 || lat !== 1) begin fails++; $display("[TB] FAIL remu_zero: got %h lat %0d expected 12345678 lat 1", res, lat); end
        applyStimulus(F_DIV, 32'hFFFFFFFB, 32'h0, lat, res);
        checks++; if (res !== 32'hFFFFFFFF) begin fails++; $display("[TB] FAIL div_zero: got %h expected FFFFFFFF", res); end
        applyStimulus(F_REM, 32'hFFFFFFFB, 32'h0, lat, res);
        checks++; if (res !== 32'hFFFFFFFB) begin fails++; $display("[TB] FAIL rem_zero: got %h expected FFFFFFFB", res); end
    endtask

    task automatic test_overflow();
        int lat; logic [31:0] res;
        applyStimulus(F_DIV, 32'h80000000, 32'hFFFFFFFF, lat, res);
        checks++; if (res !== 32'h80000000 || lat !== 1) begin fails++; $display("[TB] FAIL div_overflow: got %h lat %0d expected 80000000 lat 1", res, lat); end
        applyStimulus(F_REM, 32'h80000000, 32'hFFFFFFFF, lat, res);
        checks++; if (res !== 32'h0 || lat !== 1) begin fails++; $display("[TB] FAIL rem_overflow: got %h lat %0d expected 00000000 lat 1", res, lat); end
    endtask

    task automatic test_mul();
        int lat; logic [31:0] res;
        applyStimulus(F_MULH, 32'h80000000, 32'h80000000, lat, res);
        checks++; if (lat !== MUL_LAT) begin fails++; $display("[TB] FAIL mul_latency: got %0d expected %0d", lat, MUL_LAT); end
        checks++; if (res !== 32'h40000000) begin fails++; $display("[TB] FAIL mulh_minint: got %h expected 40000000", res); end
        applyStimulus(F_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res);
        checks++; if (res !== 32'hFFFFFFFF) begin fails++; $display("[TB] FAIL mulhsu_ones: got %h expected FFFFFFFF", res); end
        applyStimulus(F_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res);
        checks++; if (res !== 32'hFFFFFFFE) begin fails++; $display("[TB] FAIL mulhu_ones: got %h expected FFFFFFFE", res); end
        applyStimulus(F_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res);
        checks++; if (res !== 32'h1 || lat !== MUL_LAT) begin fails++; $display("[TB] FAIL mul_ones: got %h lat %0d expected 00000001 lat %0d", res, lat, MUL_LAT); end
        applyStimulus(F_MUL, 32'd7, 32'hFFFFFFFD, lat, res);
        checks++; if (res !== 32'hFFFFFFEB) begin fails++; $display("[TB] FAIL mul_7_neg3: got %h expected FFFFFFEB", res); end
        applyStimulus(F_MULH, 32'd7, 32'hFFFFFFFD, lat, res);
        checks++; if (res !== 32'hFFFFFFFF) begin fails++; $display("[TB] FAIL mulh_7_neg3: got %h expected FFFFFFFF", res); end
        applyStimulus(F_MULHU, 32'h12345678, 32'h9ABCDEF0, lat, res);
        checks++; if (res !== 32'h0B00EA4E) begin fails++; $display("[TB] FAIL mulhu_mixed: got %h expected 0B00EA4E", res); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.done_o !== 1'b0 || bus.result_o !== 32'h0B00EA4E) begin fails++; $display("[TB] FAIL result_hold: got done %b result %h expected done 0 result 0B00EA4E", bus.done_o, bus.result_o); end
    endtask

    task automatic test_flush();
        int lat; logic [31:0] res;
        bit early;
        bit moved;
        applyStimulus(F_DIVU, 32'd100, 32'd7, lat, res);
        checks++; if (res !== 32'd14) begin fails++; $display("[TB] FAIL flush_setup: got %h expected 0000000E", res); end
        @(negedge clk);
        @(negedge clk);
        bus.funct3_i = F_DIV; bus.op_a_i = 32'hFFFFFFF9; bus.op_b_i = 32'h2; bus.start_i = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        early = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (bus.done_o || !bus.busy_o) early = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (early !== 1'b0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin fails++; $display("[TB] FAIL flush_abort: got early %b busy %b done %b expected 0 0 0", early, bus.busy_o, bus.done_o); end
        checks++; if (bus.result_o !== 32'd14) begin fails++; $display("[TB] FAIL flush_result_kept: got %h expected 0000000E", bus.result_o); end
        bus.flush_i = 1'b0;
        bus.funct3_i = F_DIVU; bus.op_a_i = 32'd200; bus.op_b_i = 32'd9; bus.start_i = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        lat = -1; res = 'x; moved = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (bus.done_o) begin lat = k; res = bus.result_o; break; end
            if (bus.result_o !== 32'd14) moved = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++; if (lat !== 33 || res !== 32'd22) begin fails++; $display("[TB] FAIL flush_restart: got lat %0d result %h expected lat 33 result 00000016", lat, res); end
        checks++; if (moved !== 1'b0) begin fails++; $display("[TB] FAIL result_stable_in_iter: got changed %b expected 0", moved); end
        @(negedge clk);
        @(negedge clk);
        bus.funct3_i = F_DIVU; bus.start_i = 1'b1; bus.flush_i = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0; bus.flush_i = 1'b0;
        checks++; if (bus.busy_o !== 1'b0) begin fails++; $display("[TB] FAIL start_with_flush_dropped: got busy %b expected 0", bus.busy_o); end
    endtask

    task automatic test_reset_mid();
        bit sawDone;
        @(negedge clk);
        bus.funct3_i = F_DIVU; bus.op_a_i = 32'd1000; bus.op_b_i = 32'd3; bus.start_i = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.result_o !== 32'h0) begin fails++; $display("[TB] FAIL reset_mid_iter: got busy %b done %b result %h expected 0 0 00000000", bus.busy_o, bus.done_o, bus.result_o); end
        @(negedge clk);
        rst_n = 1'b1;
        sawDone = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done_o || bus.busy_o) sawDone = 1'b1;
        end
        checks++; if (sawDone !== 1'b0) begin fails++; $display("[TB] FAIL reset_discards_op: got activity %b expected 0", sawDone); end
    endtask

    task automatic test_back_to_back();
        int doneCycles[$];
        bit badRes;
        @(negedge clk);
        bus.funct3_i = F_DIVU; bus.op_a_i = 32'd1000; bus.op_b_i = 32'd10; bus.start_i = 1'b1;
        badRes = 1'b0;
        for (int c = 1; c <= 105; c++) begin
            @(posedge clk);
            #1;
            if (bus.done_o) begin
                doneCycles.push_back(c);
                if (bus.result_o !== 32'd100) badRes = 1'b1;
            end
        end
        bus.start_i = 1'b0;
        checks++; if (doneCycles.size() !== 3) begin fails++; $display("[TB] FAIL b2b_count: got %0d expected 3", doneCycles.size()); end
        checks++;
        if (doneCycles.size() < 3 || doneCycles[0] !== 33 || doneCycles[1] !== 67 || doneCycles[2] !== 101) begin
            fails++;
            $display("[TB] FAIL b2b_spacing: got %p expected '{33, 67, 101}", doneCycles);
        end
        checks++; if (badRes !== 1'b0) begin fails++; $display("[TB] FAIL b2b_result: got wrong result %b expected 0", badRes); end
        for (int w = 0; w < 100 && bus.busy_o; w++) @(posedge clk);
    endtask

    initial begin
        bus.start_i = 1'b0; bus.flush_i = 1'b0; bus.funct3_i = 3'b000;
        bus.op_a_i = 32'h0; bus.op_b_i = 32'h0;
        test_reset();
        test_div();
        test_div_zero();
        test_overflow();
        test_mul();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
